// File: rtl/sd_host_pkg.sv
// Shared SD host definitions used by the CMD arbiter, its watchdog and the
// DAT-path controller.
//   - CMD field widths (index 6 bits, argument 32 bits)
//   - requester IDs recorded as the owner of an in-flight command
//   - arbiter state encoding
//   - CMD12 (STOP_TRANSMISSION), the usual auto-command index
package sd_host_pkg;

  localparam int CMD_IDX_W = 6;
  localparam int CMD_ARG_W = 32;
  localparam int RSP_W     = 32;

  localparam logic [CMD_IDX_W-1:0] CMD12_INDEX = 6'd12;

  // Owner of the command currently held by the arbiter
  localparam logic REQ_SW   = 1'b0;
  localparam logic REQ_AUTO = 1'b1;

  // Arbiter states. These are kept as plain constants so older tools and
  // register dumps can decode them.
  typedef logic [2:0] arb_state_t;
  localparam arb_state_t ST_IDLE      = 3'd0;
  localparam arb_state_t ST_ISSUE     = 3'd1;
  localparam arb_state_t ST_WAIT_ACK  = 3'd2;
  localparam arb_state_t ST_WAIT_DONE = 3'd3;
  localparam arb_state_t ST_RESP      = 3'd4;

endpackage

// File: rtl/cmd_arbiter_if.sv
// Bundle of every handshake between the CMD arbiter and its neighbours:
// the two requesters (software register path, DAT-path auto command) and
// the CMD line engine.
//   slave  : arbiter view (requests/engine status in, grants/commands out)
//   master : environment view (requesters + CMD engine)
interface cmd_arbiter_if;
  import sd_host_pkg::*;

  // Software requester
  logic                 sw_req;
  logic [CMD_IDX_W-1:0] sw_cmd_index;
  logic [CMD_ARG_W-1:0] sw_cmd_arg;
  logic                 sw_grant;
  logic                 sw_done;
  logic                 sw_error;

  // Auto-command requester
  logic                 auto_req;
  logic [CMD_IDX_W-1:0] auto_cmd_index;
  logic [CMD_ARG_W-1:0] auto_cmd_arg;
  logic                 auto_grant;
  logic                 auto_done;
  logic                 auto_error;

  // Shared status
  logic [RSP_W-1:0]     rsp_status;
  logic                 arb_busy;

  // CMD engine
  logic                 new_cmd;
  logic [CMD_IDX_W-1:0] cmd_index;
  logic [CMD_ARG_W-1:0] cmd_arg;
  logic                 cmd_busy;
  logic                 cmd_complete;
  logic                 timeout_error;
  logic [RSP_W-1:0]     response_status;

  modport slave (
    input  sw_req, sw_cmd_index, sw_cmd_arg,
    input  auto_req, auto_cmd_index, auto_cmd_arg,
    input  cmd_busy, cmd_complete, timeout_error, response_status,
    output sw_grant, sw_done, sw_error,
    output auto_grant, auto_done, auto_error,
    output rsp_status, arb_busy,
    output new_cmd, cmd_index, cmd_arg
  );

  modport master (
    output sw_req, sw_cmd_index, sw_cmd_arg,
    output auto_req, auto_cmd_index, auto_cmd_arg,
    output cmd_busy, cmd_complete, timeout_error, response_status,
    input  sw_grant, sw_done, sw_error,
    input  auto_grant, auto_done, auto_error,
    input  rsp_status, arb_busy,
    input  new_cmd, cmd_index, cmd_arg
  );

endinterface

// File: rtl/cmd_ack_watchdog.sv
// Acknowledge watchdog: counts enabled cycles after a clear and flags
// expiry once TIMEOUT cycles have been counted. Shared with the DAT
// controller, so it knows nothing about the arbiter's states.
// Ports:
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   clear   : restart the count from zero (wins over enable)
//   enable  : count this cycle
//   expired : count has reached TIMEOUT; holds until the next clear
module cmd_ack_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  assign expired = (count == CNT_W'(TIMEOUT));

  // Saturate at TIMEOUT so a late enable cannot wrap back to "not expired"
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cmd_arbiter.sv
// CMD line arbiter. Grants the single CMD engine to either the software
// register path or the DAT-path auto-command source (auto has fixed
// priority), launches the latched command, waits for the engine's
// acknowledge and completion, and returns done/error to the owner.
// Ports:
//   CLK_host : host clock, all logic on the rising edge
//   reset    : asynchronous active-low reset
//   bus      : cmd_arbiter_if.slave (requesters + CMD engine handshake)
// Build option:
//   CMD_RETRY_EN : when defined, a CMD timeout_error re-issues the same
//                  command up to MAX_RETRY times before reporting an error.
module cmd_arbiter
  import sd_host_pkg::*;
#(
  parameter int ACK_TIMEOUT = 16,
  parameter int MAX_RETRY   = 2
) (
  input logic          CLK_host,
  input logic          reset,
  cmd_arbiter_if.slave bus
);

  if (ACK_TIMEOUT < 1) begin : g_bad_ack_timeout
    $error("cmd_arbiter: ACK_TIMEOUT must be at least 1");
  end
  if (MAX_RETRY < 0) begin : g_bad_max_retry
    $error("cmd_arbiter: MAX_RETRY must not be negative");
  end

  arb_state_t           state;
  logic                 owner;
  logic [CMD_IDX_W-1:0] cmd_index_q;
  logic [CMD_ARG_W-1:0] cmd_arg_q;
  logic [RSP_W-1:0]     rsp_q;
  logic                 new_cmd_q;
  logic                 sw_grant_q, auto_grant_q;
  logic                 sw_done_q, auto_done_q;
  logic                 sw_error_q, auto_error_q;
  logic                 ack_expired;
  logic                 finish_cmd;
  logic                 finish_err;

`ifdef CMD_RETRY_EN
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RETRY_W-1:0] retry_cnt;
  logic               retry_now;
`endif

  cmd_ack_watchdog #(
    .TIMEOUT (ACK_TIMEOUT)
  ) u_ack_watchdog (
    .clk     (CLK_host),
    .rst_n   (reset),
    .clear   (state == ST_ISSUE),
    .enable  (state == ST_WAIT_ACK),
    .expired (ack_expired)
  );

  // Decide whether this cycle ends the command (moving to RESP) and with
  // what error status. An acknowledge arriving on the expiry cycle wins;
  // a timeout_error on the same cycle as cmd_complete counts as a timeout.
  always_comb begin
    finish_cmd = 1'b0;
    finish_err = 1'b0;
`ifdef CMD_RETRY_EN
    retry_now  = 1'b0;
`endif
    case (state)
      ST_WAIT_ACK: begin
        if (!bus.cmd_busy && ack_expired) begin
          finish_cmd = 1'b1;
          finish_err = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (bus.timeout_error) begin
`ifdef CMD_RETRY_EN
          if (retry_cnt < RETRY_W'(MAX_RETRY)) begin
            retry_now = 1'b1;
          end else begin
            finish_cmd = 1'b1;
            finish_err = 1'b1;
          end
`else
          finish_cmd = 1'b1;
          finish_err = 1'b1;
`endif
        end else if (bus.cmd_complete) begin
          finish_cmd = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Main FSM. Grant/done/error are single-cycle pulses cleared by default
  // every cycle; cmd_index/cmd_arg only change on a grant.
  always_ff @(posedge CLK_host or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      owner        <= REQ_SW;
      cmd_index_q  <= '0;
      cmd_arg_q    <= '0;
      rsp_q        <= '0;
      new_cmd_q    <= 1'b0;
      sw_grant_q   <= 1'b0;
      auto_grant_q <= 1'b0;
      sw_done_q    <= 1'b0;
      auto_done_q  <= 1'b0;
      sw_error_q   <= 1'b0;
      auto_error_q <= 1'b0;
`ifdef CMD_RETRY_EN
      retry_cnt    <= '0;
`endif
    end else begin
      sw_grant_q   <= 1'b0;
      auto_grant_q <= 1'b0;
      sw_done_q    <= 1'b0;
      auto_done_q  <= 1'b0;
      sw_error_q   <= 1'b0;
      auto_error_q <= 1'b0;

      if (finish_cmd) begin
        state     <= ST_RESP;
        new_cmd_q <= 1'b0;
        if (owner == REQ_AUTO) begin
          auto_done_q  <= 1'b1;
          auto_error_q <= finish_err;
        end else begin
          sw_done_q  <= 1'b1;
          sw_error_q <= finish_err;
        end
        // A failed command leaves the previous response visible
        if (!finish_err) begin
          rsp_q <= bus.response_status;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (bus.auto_req) begin
              auto_grant_q <= 1'b1;
              owner        <= REQ_AUTO;
              cmd_index_q  <= bus.auto_cmd_index;
              cmd_arg_q    <= bus.auto_cmd_arg;
              state        <= ST_ISSUE;
`ifdef CMD_RETRY_EN
              retry_cnt    <= '0;
`endif
            end else if (bus.sw_req) begin
              sw_grant_q  <= 1'b1;
              owner       <= REQ_SW;
              cmd_index_q <= bus.sw_cmd_index;
              cmd_arg_q   <= bus.sw_cmd_arg;
              state       <= ST_ISSUE;
`ifdef CMD_RETRY_EN
              retry_cnt   <= '0;
`endif
            end
          end
          ST_ISSUE: begin
            new_cmd_q <= 1'b1;
            state     <= ST_WAIT_ACK;
          end
          ST_WAIT_ACK: begin
            if (bus.cmd_busy) begin
              new_cmd_q <= 1'b0;
              state     <= ST_WAIT_DONE;
            end
          end
          ST_WAIT_DONE: begin
`ifdef CMD_RETRY_EN
            // Re-issue the latched command; no new grant is produced
            if (retry_now) begin
              retry_cnt <= retry_cnt + 1'b1;
              state     <= ST_ISSUE;
            end
`endif
          end
          ST_RESP: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.sw_grant   = sw_grant_q;
  assign bus.auto_grant = auto_grant_q;
  assign bus.sw_done    = sw_done_q;
  assign bus.auto_done  = auto_done_q;
  assign bus.sw_error   = sw_error_q;
  assign bus.auto_error = auto_error_q;
  assign bus.rsp_status = rsp_q;
  assign bus.arb_busy   = (state != ST_IDLE);
  assign bus.new_cmd    = new_cmd_q;
  assign bus.cmd_index  = cmd_index_q;
  assign bus.cmd_arg    = cmd_arg_q;

endmodule

// File: doc/cmd_arbiter.md
Name: cmd_arbiter

Overview:
Arbitrates the single CMD line engine (CMD block) between two requesters: the host software register path and the DAT-path auto-command source (e.g. CMD12 stop). Grants one requester, latches its index/argument, drives the CMD engine handshake and waits for completion or timeout. Returns the response status and an error flag to the owning requester. Sits between the host register file / DAT controller and CMD, entirely in the CLK_host domain.

Parameters:
ACK_TIMEOUT, 16, CLK_host cycles to wait for cmd_busy after new_cmd rises before declaring an acknowledge error
MAX_RETRY, 2, re-issues after a CMD timeout_error (used only with CMD_RETRY_EN)

Ports:
CLK_host  in  1  host clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
sw_req  in  1  software request; level, held until sw_grant
sw_cmd_index  in  6  software command index
sw_cmd_arg  in  32  software command argument
auto_req  in  1  auto-command request; level, held until auto_grant
auto_cmd_index  in  6  auto command index
auto_cmd_arg  in  32  auto command argument
sw_grant / auto_grant  out  1 each  one-cycle pulse: request accepted, fields latched
sw_done / auto_done  out  1 each  one-cycle completion pulse to owner
sw_error / auto_error  out  1 each  valid with matching done: command failed
rsp_status  out  32  response of last completed command; held until next completion
arb_busy  out  1  high in every state except IDLE
new_cmd  out  1  to CMD: command start, level
cmd_index  out  6  to CMD: latched index
cmd_arg  out  32  to CMD: latched argument
cmd_busy  in  1  from CMD: engine busy
cmd_complete  in  1  from CMD: command/response done
timeout_error  in  1  from CMD: no response from card
response_status  in  32  from CMD: response payload

Behaviour:
- Reset (reset low, asynchronous): state IDLE; all outputs 0; rsp_status 0; counters 0; owner 0.
- States: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, RESP.
- IDLE: if auto_req, grant auto; else if sw_req, grant sw (fixed priority, auto wins on simultaneous). Grant cycle: pulse grant, latch index/arg into cmd_index/cmd_arg, record owner, clear retry counter, -> ISSUE.
- ISSUE: new_cmd=1, clear watchdog, -> WAIT_ACK next cycle.
- WAIT_ACK: new_cmd held 1; watchdog increments each cycle. cmd_busy=1 -> new_cmd=0, -> WAIT_DONE. Watchdog reaches ACK_TIMEOUT first -> new_cmd=0, error=1, -> RESP.
- WAIT_DONE: new_cmd=0. timeout_error=1 -> error (see feature), -> RESP. cmd_complete=1 (timeout_error=0) -> latch response_status into rsp_status, error=0, -> RESP. Both same cycle -> treated as timeout.
- RESP: one cycle; pulse owner's done, drive owner's error; other requester's done/error stay 0; -> IDLE. rsp_status unchanged on error.
- Grant-to-new_cmd latency: 1 cycle. Minimum 1 IDLE cycle between commands; a request held through RESP is granted in the following IDLE cycle.
- cmd_index/cmd_arg stable from grant until next grant; requester changes after grant ignored.
- Request withdrawn before grant: no effect. Reset mid-command: abort immediately, no done pulse, new_cmd low.

Optional Feature:
CMD_RETRY_EN defined: timeout_error in WAIT_DONE with retry count < MAX_RETRY -> increment count, -> ISSUE (re-issue same latched command, no new grant). Count = MAX_RETRY -> error, -> RESP. Ack-watchdog expiry never retried.
Not defined: first timeout_error reported as error; no retry counter.

Decomposition:
- Shared package sd_host_pkg: state encoding, requester ID constants (REQ_SW, REQ_AUTO), CMD index/arg widths (6, 32), CMD12 index constant.
- One sub-module: cmd_ack_watchdog (clear/enable/expired, width from ACK_TIMEOUT), reusable by DAT controller.

Test Plan:
- sw_req, index 6'h11, arg 32'h6666_6666; CMD raises cmd_busy 3 cycles after new_cmd, cmd_complete with response 32'hCACA_DEF3 -> sw_grant pulse, new_cmd 1 cycle later, sw_done=1, sw_error=0, rsp_status=32'hCACA_DEF3.
- sw_req and auto_req same cycle (auto index 6'h0C) -> auto_grant first, cmd_index=6'h0C; sw_grant in IDLE cycle after auto_done.
- cmd_busy never asserted, ACK_TIMEOUT=16 -> new_cmd high exactly 17 cycles (ISSUE+16), sw_done with sw_error=1, rsp_status unchanged.
- timeout_error and cmd_complete same cycle, macro off -> sw_error=1, rsp_status unchanged.
- CMD_RETRY_EN, MAX_RETRY=2, three timeout_errors -> new_cmd rises 3 times, single sw_done with sw_error=1; two timeouts then complete -> sw_error=0.
- reset low during WAIT_DONE -> all outputs 0 asynchronously, no done pulse; after release new request proceeds normally.
